// File: rtl/chaser_ctrl.sv
// chaser_ctrl - upstream control stage for the PWM LED chaser.
//
// Three raw active-low pushbuttons are synchronized, debounced and turned
// into one-cycle press events that drive the chase direction, a 3-bit rate
// level and a RUN/PAUSE state. A prescaler plus tick counter produce
// `step`, a registered one-cycle pulse every TICK_DIV*2*(8-speed) cycles
// while running.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   key_dir    raw button, active-low: press toggles sentido
//   key_speed  raw button, active-low: press advances speed (7 wraps to 0)
//   key_pause  raw button, active-low: press toggles RUN/PAUSE
//   sentido    chase direction (1 = toward lower index)
//   speed      rate level 0..7
//   paused     1 while in PAUSE
//   step       one-cycle advance pulse to the chaser
module chaser_ctrl #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned TICK_DIV  = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_dir,
    input  logic       key_speed,
    input  logic       key_pause,
    output logic       sentido,
    output logic [2:0] speed,
    output logic       paused,
    output logic       step
);

    localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_PAUSE = 1'b1;

    localparam int unsigned K_DIR   = 0;
    localparam int unsigned K_SPEED = 1;
    localparam int unsigned K_PAUSE = 2;

    // ------------------------------------------------------------------
    // Key conditioning: 2-flop synchronizer, debouncer, press detector
    // ------------------------------------------------------------------
    logic [2:0]          keys;
    logic [2:0]          sync1_q, sync2_q;
    logic [2:0]          db_q, db_d;
    logic [2:0][DBW-1:0] dbcnt_q, dbcnt_d;
    logic [2:0]          ev_q, ev_d;

    assign keys = {key_pause, key_speed, key_dir};

    always_comb begin
        db_d    = db_q;
        dbcnt_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dbcnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dbcnt_d[i] = dbcnt_q[i] + DBW'(1);
                end
            end
        end
        // Press = debounced level about to fall; registering it here puts
        // the event in the cycle right after the debounced level drops.
        ev_d = db_q & ~db_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            dbcnt_q <= '0;
            ev_q    <= '0;
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dbcnt_q <= dbcnt_d;
            ev_q    <= ev_d;
        end
    end

    // ------------------------------------------------------------------
    // Control state, rate generator and step pulse
    // ------------------------------------------------------------------
    logic           sentido_q, sentido_d;
    logic [2:0]     speed_q, speed_d;
    logic [0:0]     state_q, state_d;
    logic           step_q, step_d;
    logic [PSW-1:0] pre_q, pre_d;
    logic [3:0]     tick_q, tick_d;
    logic [3:0]     p_last;
    logic           run, pre_term, tick_term;

    // P-1 = 2*(8-speed)-1 = 15 - 2*speed, always fits the 4-bit counter.
    assign p_last    = 4'd15 - {speed_q, 1'b0};
    assign run       = (state_q == ST_RUN);
    assign pre_term  = (pre_q == PS_LAST);
    assign tick_term = (tick_q == p_last);

    always_comb begin
        sentido_d = sentido_q;
        speed_d   = speed_q;
        state_d   = state_q;
        pre_d     = pre_q;
        tick_d    = tick_q;
        step_d    = run & pre_term & tick_term;

        if (run) begin
            if (pre_term) begin
                pre_d  = '0;
                tick_d = tick_term ? 4'd0 : tick_q + 4'd1;
            end else begin
                pre_d = pre_q + PSW'(1);
            end
        end

        if (ev_q[K_DIR]) begin
            sentido_d = ~sentido_q;
        end

        // Speed change restarts the period; overrides the advance above
        // so a terminal-cycle step still fires but counting restarts at 0.
        if (ev_q[K_SPEED]) begin
            speed_d = speed_q + 3'd1;
            pre_d   = '0;
            tick_d  = '0;
        end

        if (ev_q[K_PAUSE]) begin
            state_d = run ? ST_PAUSE : ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sentido_q <= 1'b0;
            speed_q   <= 3'd3;
            state_q   <= ST_RUN;
            step_q    <= 1'b0;
            pre_q     <= '0;
            tick_q    <= '0;
        end else begin
            sentido_q <= sentido_d;
            speed_q   <= speed_d;
            state_q   <= state_d;
            step_q    <= step_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
        end
    end

    assign sentido = sentido_q;
    assign speed   = speed_q;
    assign paused  = (state_q == ST_PAUSE);
    assign step    = step_q;

endmodule

// File: tb/tb_chaser_ctrl.sv
// Bench for chaser_ctrl with DB_CYCLES=4, TICK_DIV=5.
// Expected step edges are queued ahead of time from period arithmetic and
// popped by a monitor whenever step is seen high; key presses come from a
// table of {press edge, key, expected outputs after the event}.
module tb_chaser_ctrl;

    localparam int DB = 4;
    localparam int TD = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_dir = 1'b1;
    logic       key_speed = 1'b1;
    logic       key_pause = 1'b1;
    logic       sentido;
    logic [2:0] speed;
    logic       paused;
    logic       step;

    chaser_ctrl #(
        .DB_CYCLES(DB),
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_dir  (key_dir),
        .key_speed(key_speed),
        .key_pause(key_pause),
        .sentido  (sentido),
        .speed    (speed),
        .paused   (paused),
        .step     (step)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int e_step;

    // step-schedule model
    int nxt, per, rem;
    bit running;
    logic       m_sentido;
    logic [2:0] m_speed;
    logic       m_paused;

    typedef struct {
        int         at;
        int         kid;
        logic       sen;
        logic [2:0] spd;
        logic       pau;
    } press_t;
    press_t tbl[14];

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // scoreboard: every step pulse must match the next queued edge
    always @(posedge clk) begin
        #2;
        if (!rst && step === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL step_unexpected: step high at edge %0d, none due", cyc);
            end else begin
                e_step = exp_q.pop_front();
                if (e_step != cyc) begin
                    n_bad++;
                    $display("FAIL step_edge: step at edge %0d, expected edge %0d", cyc, e_step);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: edge %0d got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic expect_until(input int n);
        while (running && nxt <= n) begin
            exp_q.push_back(nxt);
            nxt += per;
        end
    endtask

    task automatic wait_to(input int n);
        expect_until(n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       key_dir   = v;
            1:       key_speed = v;
            default: key_pause = v;
        endcase
    endtask

    task automatic model_reset();
        running   = 1'b1;
        per       = 2 * 5 * TD;
        nxt       = per;
        m_sentido = 1'b0;
        m_speed   = 3'd3;
        m_paused  = 1'b0;
    endtask

    initial begin
        int e;
        //            at   key sentido speed paused   (after the event)
        tbl[0]  = '{ 250, 0, 1'b0, 3'd3, 1'b0};
        tbl[1]  = '{ 280, 1, 1'b0, 3'd4, 1'b0};
        tbl[2]  = '{ 300, 1, 1'b0, 3'd5, 1'b0};
        tbl[3]  = '{ 320, 1, 1'b0, 3'd6, 1'b0};
        tbl[4]  = '{ 340, 1, 1'b0, 3'd7, 1'b0};  // lands on a step terminal
        tbl[5]  = '{ 380, 1, 1'b0, 3'd0, 1'b0};  // lands on a step terminal
        tbl[6]  = '{ 560, 1, 1'b0, 3'd1, 1'b0};
        tbl[7]  = '{ 580, 1, 1'b0, 3'd2, 1'b0};
        tbl[8]  = '{ 600, 1, 1'b0, 3'd3, 1'b0};
        tbl[9]  = '{ 632, 2, 1'b0, 3'd3, 1'b1};  // holds at prescaler=2, tick=6
        tbl[10] = '{ 932, 2, 1'b0, 3'd3, 1'b0};  // resume: step 18 edges later
        tbl[11] = '{ 960, 0, 1'b1, 3'd3, 1'b0};
        tbl[12] = '{ 980, 1, 1'b1, 3'd4, 1'b0};
        tbl[13] = '{1000, 2, 1'b1, 3'd4, 1'b1};

        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sentido", sentido, 0);
        chk("rst_speed", speed, 3);
        chk("rst_paused", paused, 0);
        chk("rst_step", step, 0);
        rst = 1'b0;

        // free run: steps at 50, 100, 150, 200
        wait_to(200);
        chk("run_sentido", sentido, 0);
        chk("run_speed", speed, 3);
        chk("run_paused", paused, 0);

        // bouncy dir press: low 2, high 1, then held low from edge 203
        key_dir = 1'b0;
        wait_to(202);
        key_dir = 1'b1;
        wait_to(203);
        key_dir = 1'b0;
        wait_to(209);
        chk("bounce_sentido_early", sentido, 0);
        wait_to(210);
        chk("bounce_sentido", sentido, 1);
        m_sentido = 1'b1;
        wait_to(230);
        key_dir = 1'b1;
        wait_to(245);
        chk("release_no_event", sentido, 1);

        for (int i = 0; i < 14; i++) begin
            wait_to(tbl[i].at);
            set_key(tbl[i].kid, 1'b0);
            e = tbl[i].at + DB + 3;
            wait_to(e - 1);
            chk("pre_sentido", sentido, m_sentido);
            chk("pre_speed", speed, m_speed);
            chk("pre_paused", paused, m_paused);
            expect_until(e);
            if (tbl[i].kid == 1) begin
                per = 2 * (8 - int'(tbl[i].spd)) * TD;
                nxt = e + per;
            end else if (tbl[i].kid == 2) begin
                if (tbl[i].pau) begin
                    rem     = nxt - e;
                    running = 1'b0;
                end else begin
                    nxt     = e + rem;
                    running = 1'b1;
                end
            end
            m_sentido = tbl[i].sen;
            m_speed   = tbl[i].spd;
            m_paused  = tbl[i].pau;
            wait_to(e);
            chk("post_sentido", sentido, tbl[i].sen);
            chk("post_speed", speed, tbl[i].spd);
            chk("post_paused", paused, tbl[i].pau);
            wait_to(tbl[i].at + 10);
            set_key(tbl[i].kid, 1'b1);
        end

        // reset mid-debounce with key_dir held low and state away from reset
        wait_to(1020);
        key_dir = 1'b0;
        wait_to(1023);
        rst = 1'b1;
        #1;
        chk("midrst_sentido", sentido, 0);
        chk("midrst_speed", speed, 3);
        chk("midrst_paused", paused, 0);
        chk("midrst_step", step, 0);
        chk("sb_pending_before_reset", exp_q.size(), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_to(6);
        chk("held_key_sentido_early", sentido, 0);
        wait_to(7);
        chk("held_key_sentido", sentido, 1);
        wait_to(20);
        key_dir = 1'b1;
        wait_to(110);
        chk("sb_pending_at_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
